// File: rtl/test_pattern_writer.sv
// Paints an IMG_WIDTH x IMG_HEIGHT test image into pixel RAM, one word per pixel, two clocks per pixel.
// Optional macro TEST_PATTERN_ACK_EN adds mem_ack: a write is held until the RAM acknowledges it.
module test_pattern_writer #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] starting_address,
  input  logic [23:0]           solid_color,
  output logic [DATA_WIDTH-1:0] data_write,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wren,
`ifdef TEST_PATTERN_ACK_EN
  input  logic                  mem_ack,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int CW = 13;
  localparam logic [CW-1:0]         X_LAST    = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0]         Y_LAST    = CW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0]         HH        = CW'(IMG_HEIGHT / 2);
  localparam logic [CW-1:0]         HHQ       = CW'(IMG_HEIGHT / 2 + IMG_HEIGHT / 4);
  localparam logic [CW-1:0]         QC_LAST   = CW'(IMG_WIDTH / 32 - 1);
  localparam logic [CW-1:0]         W_C       = CW'(IMG_WIDTH);
  localparam logic [CW-1:0]         RAMP_REM  = CW'(256 % IMG_WIDTH);
  localparam logic [7:0]            RAMP_INC  = 8'(256 / IMG_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;
  state_t state, state_next;

  logic [1:0]            mode_q;
  logic [23:0]           sol_q;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [CW-1:0]         x, y;
  logic [CW-1:0]         qc;      // column within the current quarter-bar
  logic [4:0]            q;       // quarter-bar index: bar = q[4:2], sub-column = q[1:0]
  logic [7:0]            v;       // running x*256/IMG_WIDTH
  logic [CW-1:0]         rem, rem_sum;
  logic                  is_last;

  logic [23:0]           bar_pix, pix;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [DATA_WIDTH-1:0] data_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  wren_d, busy_d, done_d;

  assign is_last  = (x == X_LAST) && (y == Y_LAST);
  assign rem_sum  = rem + RAMP_REM;
  assign pix_addr = line_addr + ADDR_WIDTH'(x);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // wren is the valid; without mem_ack the RAM is always ready, with it
  // the write completes on the edge that sees wren && mem_ack.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (enable) state_next = WRITE;
`ifdef TEST_PATTERN_ACK_EN
      WRITE: if (wren && mem_ack) state_next = GAP;
`else
      WRITE: state_next = GAP;
`endif
      GAP:   state_next = is_last ? DONE : WRITE;
      DONE:  if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wren_d = 1'b0;
    addr_d = '0;
    data_d = '0;
    busy_d = (state_next == WRITE) || (state_next == GAP);
    done_d = 1'b0;
    case (state)
      WRITE: begin
        wren_d = 1'b1;
        addr_d = pix_addr;
        data_d = DATA_WIDTH'(pix);
`ifdef TEST_PATTERN_ACK_EN
        if (wren && mem_ack) begin
          wren_d = 1'b0;
          addr_d = addr;
          data_d = data_write;
        end
`endif
      end
      GAP: begin
        addr_d = addr;
        data_d = data_write;
      end
      DONE:    done_d = enable;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wren       <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wren       <= wren_d;
      addr       <= addr_d;
      data_write <= data_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 2'd0;
      sol_q     <= 24'h0;
      line_addr <= '0;
      x         <= '0;
      y         <= '0;
      qc        <= '0;
      q         <= 5'd0;
      v         <= 8'd0;
      rem       <= '0;
    end else if (state == IDLE && enable) begin
      mode_q    <= mode;
      sol_q     <= solid_color;
      line_addr <= starting_address;
      x         <= '0;
      y         <= '0;
      qc        <= '0;
      q         <= 5'd0;
      v         <= 8'd0;
      rem       <= '0;
    end else if (state == GAP) begin
      if (x == X_LAST) begin
        x         <= '0;
        qc        <= '0;
        q         <= 5'd0;
        v         <= 8'd0;
        rem       <= '0;
        y         <= y + CW'(1);
        line_addr <= line_addr + LINE_STEP;
      end else begin
        x <= x + CW'(1);
        if (qc == QC_LAST) begin
          qc <= '0;
          q  <= q + 5'd1;
        end else begin
          qc <= qc + CW'(1);
        end
        // Bresenham-style step keeps the ramp exact for non-power-of-two widths
        if (rem_sum >= W_C) begin
          v   <= v + RAMP_INC + 8'd1;
          rem <= rem_sum - W_C;
        end else begin
          v   <= v + RAMP_INC;
          rem <= rem_sum;
        end
      end
    end
  end

  always_comb begin
    bar_pix = 24'h0;
    if (y < HH) begin
      case (q[4:2])
        3'd0: bar_pix = 24'hC0C0C0;
        3'd1: bar_pix = 24'hC0C000;
        3'd2: bar_pix = 24'h00C0C0;
        3'd3: bar_pix = 24'h00C000;
        3'd4: bar_pix = 24'hC000C0;
        3'd5: bar_pix = 24'hC00000;
        3'd6: bar_pix = 24'h0000C0;
        3'd7: bar_pix = 24'hFFFFFF;
      endcase
    end else if (y < HHQ) begin
      case (q[4:2])
        3'd0: bar_pix = 24'h0000C0;
        3'd2: bar_pix = 24'hC000C0;
        3'd4: bar_pix = 24'h00C0C0;
        3'd6: bar_pix = 24'hC0C0C0;
        default: bar_pix = 24'h131313;
      endcase
    end else begin
      case (q[4:2])
        3'd0: bar_pix = 24'h00214C;
        3'd1: bar_pix = 24'hFFFFFF;
        3'd2: bar_pix = 24'h32006A;
        3'd4: begin
          case (q[1:0])
            2'd0: bar_pix = 24'h090909;
            2'd1: bar_pix = 24'h131313;
            2'd2: bar_pix = 24'h1D1D1D;
            2'd3: bar_pix = 24'h090909;
          endcase
        end
        3'd6: bar_pix = 24'hC0C0C0;
        default: bar_pix = 24'h131313;
      endcase
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    pix = bar_pix;
      2'd1:    pix = sol_q;
      2'd2:    pix = {v, v, v};
      default: pix = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
    endcase
  end

endmodule

// File: doc/test_pattern_writer.md
Name: test_pattern_writer

Overview:
- Parametrised successor to the fixed 32x32 colour-bar painter.
- Writes a full test image of configurable size into pixel RAM, one pixel per word, starting at a runtime base address.
- Supports four selectable patterns: SMPTE-style bars, solid colour, grey ramp and checkerboard.
- Sits beside the camera/image pipeline as a RAM-fill source for display and algorithm bring-up.

Parameters:
- IMG_WIDTH, 32, pixels per line; multiple of 32, ≤ 4096.
- IMG_HEIGHT, 32, lines; multiple of 4, ≤ 4096.
- ADDR_WIDTH, 18, RAM word-address width.
- DATA_WIDTH, 32, RAM data width; ≥ 24.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start request, level-sensitive.
- mode  in  2  pattern select: 0 bars, 1 solid, 2 ramp, 3 checker.
- starting_address  in  ADDR_WIDTH  address of pixel (0,0).
- solid_color  in  24  RGB used in mode 1.
- data_write  out  DATA_WIDTH  pixel word: zero-extended {R,G,B}.
- addr  out  ADDR_WIDTH  write address.
- wren  out  1  write strobe.
- busy  out  1  high while painting.
- done  out  1  image complete.

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: data_write=0, addr=0, wren=0, busy=0, done=0; state=IDLE.
- A reset asserted mid-image aborts the fill; outputs take their reset values at the next edge.
- States: IDLE, WRITE, GAP, DONE.
- IDLE → WRITE:
  - Taken on an edge with enable=1.
  - That edge latches mode, starting_address and solid_color; later changes to these inputs are ignored until the next start.
  - Sets x=0, y=0 and busy=1.
- WRITE (one cycle):
  - wren=1, addr=starting_address + y*IMG_WIDTH + x, data_write=pixel(x,y).
  - Next state is GAP.
- GAP (one cycle):
  - wren=0; addr and data_write hold their values.
  - Advance x. When x wraps to 0, advance y.
  - After the last pixel (IMG_WIDTH-1, IMG_HEIGHT-1), go to DONE; otherwise go to WRITE.
- Cadence: exactly 2 clocks per pixel. Pixel n has wren high in cycle 2n+1 after the start edge.
- done rises 2*IMG_WIDTH*IMG_HEIGHT+1 clocks after the start edge.
- DONE:
  - done=1, busy=0, wren=0, addr=0, data_write=0.
  - Holds while enable=1. enable=0 returns to IDLE with done cleared, re-arming the block.
- Address arithmetic is modulo 2^ADDR_WIDTH, so the image wraps through 0.
- Mode 0 (bars): bw=IMG_WIDTH/8, b=x/bw, hh=IMG_HEIGHT/2, hq=IMG_HEIGHT/4.
  - y<hh, for b=0..7: C0C0C0, C0C000, 00C0C0, 00C000, C000C0, C00000, 0000C0, FFFFFF.
  - hh≤y<hh+hq, for b=0..7: 0000C0, 131313, C000C0, 131313, 00C0C0, 131313, C0C0C0, 131313.
  - y≥hh+hq, for b=0..7: 00214C, FFFFFF, 32006A, 131313, sub, 131313, C0C0C0, 131313.
  - sub divides bar 4 into four columns of width bw/4: 090909, 131313, 1D1D1D, 090909.
- Mode 1 (solid): every pixel = latched solid_color.
- Mode 2 (ramp): v=(x*256)/IMG_WIDTH truncated to 8 bits; pixel={v,v,v}.
- Mode 3 (checker): 8x8-pixel blocks. Pixel = FFFFFF if x[3]^y[3] else 000000.
- Pixel computation is pipelined at most one stage and must meet the 2-clock cadence without added latency.

Optional Feature:
- Macro: TEST_PATTERN_ACK_EN.
- When defined:
  - Adds input port mem_ack (1 bit) after wren.
  - WRITE holds wren=1 with addr and data_write stable until an edge sees mem_ack=1; it then goes to GAP.
  - mem_ack during GAP or IDLE is ignored.
  - Reset still aborts immediately.
- When undefined: no mem_ack port; fixed 2-clock cadence as above.

Test Plan:
- Reset: hold reset 3 cycles → all outputs 0. Assert reset during pixel 100 → next edge wren=0, busy=0, and no further writes.
- Mode 0, 32x32, starting_address=0x00100:
  - pixel 0: addr 0x00100, data 0x00C0C0C0.
  - pixel 4: data 0x00C0C000.
  - pixel 512: addr 0x00300, data 0x000000C0.
  - pixel 784: data 0x00090909; pixel 785: data 0x00131313.
  - done rises at clock 2049 after the start edge.
- Mode 1, solid_color=0x123456, then change the input mid-image → all 1024 writes carry 0x00123456.
- Mode 2/3 at IMG_WIDTH=64:
  - Ramp: x=32 → data 0x00808080.
  - Checker: pixel (8,0) → 0x00FFFFFF; pixel (8,8) → 0x00000000.
- Wrap and re-arm:
  - starting_address=0x3FFFF → pixel 0 at 0x3FFFF, pixel 1 at 0x00000.
  - Keep enable high → done stays 1. Drop enable, then raise it → a second full image is written.
- With TEST_PATTERN_ACK_EN, hold mem_ack low 5 cycles on pixel 0 → wren, addr and data_write stable for 6 cycles, then pixel 1 follows.
